// File: rtl/tdm_frame_unpacker.sv
// Serial I/Q word stream to parallel TDM frame: per-channel saturating left-shift gain,
// double-buffered assembly (asm -> hold) and frame delivery on interpolator request strobes.
module tdm_frame_unpacker #(
    parameter int SAMP_WIDTH = 16,
    parameter int NUM_CHANS  = 13,
    parameter int GAIN_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              clr,
    input  logic [GAIN_WIDTH*NUM_CHANS-1:0]   gain,
    input  logic [SAMP_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              req,
    output logic                              m_valid,
    output logic [2*SAMP_WIDTH*NUM_CHANS-1:0] m_data,
    output logic [CNT_WIDTH-1:0]              underflow_cnt,
    output logic [CNT_WIDTH-1:0]              syncerr_cnt,
    output logic                              syncerr
);

    localparam int NW = 2 * NUM_CHANS;
    localparam int FW = NW * SAMP_WIDTH;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    // Wide enough that the largest shift of any input never loses its sign bit.
    localparam int EW = SAMP_WIDTH + (2 ** GAIN_WIDTH) - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    function automatic logic [SAMP_WIDTH-1:0] sat_shift(
        input logic [SAMP_WIDTH-1:0] w,
        input logic [GAIN_WIDTH-1:0] g
    );
        logic [EW-1:0]            sh;
        logic [EW-SAMP_WIDTH:0]   top;
        sh  = {{(EW-SAMP_WIDTH){w[SAMP_WIDTH-1]}}, w} << g;
        top = sh[EW-1:SAMP_WIDTH-1];
        if (top == '0 || top == '1)
            return sh[SAMP_WIDTH-1:0];
        return sh[EW-1] ? {1'b1, {(SAMP_WIDTH-1){1'b0}}}
                        : {1'b0, {(SAMP_WIDTH-1){1'b1}}};
    endfunction

    logic [IW-1:0]         widx;
    logic                  asm_full;
    logic                  hold_full;
    logic [FW-1:0]         asm_buf;
    logic [FW-1:0]         hold_buf;
    logic                  accept;
    logic [GAIN_WIDTH-1:0] cur_gain;
    logic [SAMP_WIDTH-1:0] scaled;

    always_comb begin
        s_axis_tready = !asm_full;
        accept        = s_axis_tvalid && !asm_full;
        cur_gain      = gain[int'(widx >> 1) * GAIN_WIDTH +: GAIN_WIDTH];
        scaled        = sat_shift(s_axis_tdata, cur_gain);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            widx          <= '0;
            asm_full      <= 1'b0;
            hold_full     <= 1'b0;
            asm_buf       <= '0;
            hold_buf      <= '0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            underflow_cnt <= '0;
            syncerr_cnt   <= '0;
            syncerr       <= 1'b0;
        end else if (clr) begin
            widx          <= '0;
            asm_full      <= 1'b0;
            hold_full     <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            underflow_cnt <= '0;
            syncerr_cnt   <= '0;
            syncerr       <= 1'b0;
        end else begin
            // Serving uses the hold contents from before this edge, so a same-cycle refill is safe.
            m_valid <= req;
            if (req) begin
                if (hold_full) begin
                    m_data <= hold_buf;
                end else begin
                    m_data <= '0;
                    if (underflow_cnt != '1)
                        underflow_cnt <= underflow_cnt + CNT_WIDTH'(1);
                end
            end

            if (asm_full && (!hold_full || req)) begin
                hold_buf  <= asm_buf;
                hold_full <= 1'b1;
                asm_full  <= 1'b0;
            end else if (req && hold_full) begin
                hold_full <= 1'b0;
            end

            // accept implies asm_full is low, so this never collides with the transfer above.
            if (accept) begin
                if (widx == LAST_IDX) begin
                    asm_buf[int'(widx) * SAMP_WIDTH +: SAMP_WIDTH] <= scaled;
                    asm_full <= 1'b1;
                    widx     <= '0;
                    if (!s_axis_tlast) begin
                        syncerr <= 1'b1;
                        if (syncerr_cnt != '1)
                            syncerr_cnt <= syncerr_cnt + CNT_WIDTH'(1);
                    end
                end else if (s_axis_tlast) begin
                    widx    <= '0;
                    syncerr <= 1'b1;
                    if (syncerr_cnt != '1)
                        syncerr_cnt <= syncerr_cnt + CNT_WIDTH'(1);
                end else begin
                    asm_buf[int'(widx) * SAMP_WIDTH +: SAMP_WIDTH] <= scaled;
                    widx <= widx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_frame_unpacker.sv
// Scoreboard bench for tdm_frame_unpacker: expected frames are queued at each request
// and compared when m_valid is observed.
module tb_tdm_frame_unpacker;

    localparam int SW = 16;
    localparam int NC = 13;
    localparam int GW = 5;
    localparam int CW = 16;
    localparam int NW = 2 * NC;
    localparam int FW = NW * SW;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            clr = 1'b0;
    logic [GW*NC-1:0] gain = '0;
    logic [SW-1:0]   s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tready;
    logic            req = 1'b0;
    logic            m_valid;
    logic [FW-1:0]   m_data;
    logic [CW-1:0]   underflow_cnt;
    logic [CW-1:0]   syncerr_cnt;
    logic            syncerr;

    tdm_frame_unpacker #(
        .SAMP_WIDTH(SW),
        .NUM_CHANS (NC),
        .GAIN_WIDTH(GW),
        .CNT_WIDTH (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .clr          (clr),
        .gain         (gain),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .req          (req),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .underflow_cnt(underflow_cnt),
        .syncerr_cnt  (syncerr_cnt),
        .syncerr      (syncerr)
    );

    always #5 aclk = ~aclk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   req_cnt = 0;
    int unsigned   valid_cnt = 0;
    int unsigned   exp_uf = 0;
    int            gains[NC];
    logic [SW-1:0] words[NW];
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] model_q[$];
    logic [FW-1:0] last_exp = '0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] model_sat(input logic [SW-1:0] w, input int g);
        longint v;
        v = longint'($signed(w));
        v = v * (longint'(1) << g);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return v[SW-1:0];
    endfunction

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < NW; k++)
            f[k*SW +: SW] = model_sat(words[k], gains[k/2]);
        return f;
    endfunction

    task automatic drive_gains();
        for (int i = 0; i < NC; i++)
            gain[i*GW +: GW] = GW'(gains[i]);
    endtask

    task automatic random_words();
        for (int k = 0; k < NW; k++)
            words[k] = SW'($urandom);
    endtask

    task automatic send_word(input logic [SW-1:0] d, input logic l);
        int unsigned waited = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready) begin
            @(negedge aclk);
            waited++;
            if (waited > 200) begin
                check("tready_timeout", FW'(s_axis_tready), 1);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int unsigned n, input bit with_last);
        for (int unsigned i = 0; i < n; i++)
            send_word(words[i], with_last && (i == n - 1));
        if (n == NW)
            model_q.push_back(model_frame());
    endtask

    function automatic void push_expected();
        req_cnt++;
        if (model_q.size() > 0) begin
            last_exp = model_q.pop_front();
        end else begin
            last_exp = '0;
            if (exp_uf < 32'hffff) exp_uf++;
        end
        exp_q.push_back(last_exp);
    endfunction

    task automatic do_req();
        req = 1'b1;
        push_expected();
        @(negedge aclk);
        req = 1'b0;
        check("m_valid_high", FW'(m_valid), 1);
        @(negedge aclk);
        check("m_valid_low", FW'(m_valid), 0);
        check("m_data_hold", m_data, last_exp);
    endtask

    always @(negedge aclk) begin
        if (!areset && m_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0)
                check("sb_underrun", FW'(exp_q.size()), 1);
            else
                check("m_data", m_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [FW-1:0] tmp;
        for (int i = 0; i < NC; i++) gains[i] = 0;
        drive_gains();
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        check("rst_tready", FW'(s_axis_tready), 1);
        check("rst_m_valid", FW'(m_valid), 0);
        check("rst_m_data", m_data, '0);
        check("rst_underflow", FW'(underflow_cnt), 0);
        check("rst_syncerr_cnt", FW'(syncerr_cnt), 0);
        check("rst_syncerr", FW'(syncerr), 0);

        // Ramp frame with unity gain; request at the earliest cycle hold can be full.
        for (int k = 0; k < NW; k++) words[k] = SW'(k + 1);
        send_frame(NW, 1'b1);
        @(negedge aclk);
        do_req();
        check("ramp_underflow", FW'(underflow_cnt), 0);

        // Gain and saturation corners.
        for (int i = 0; i < NC; i++) gains[i] = int'($urandom_range(0, 31));
        gains[0] = 3; gains[1] = 4; gains[2] = 4; gains[3] = 20;
        drive_gains();
        random_words();
        words[0] = 16'h0100; words[2] = 16'h1000; words[4] = 16'hF000; words[6] = 16'h0000;
        send_frame(NW, 1'b1);
        tmp = model_q.pop_back();
        tmp[0*SW +: SW] = 16'h0800;
        tmp[2*SW +: SW] = 16'h7FFF;
        tmp[4*SW +: SW] = 16'h8000;
        tmp[6*SW +: SW] = 16'h0000;
        model_q.push_back(tmp);
        repeat (2) @(negedge aclk);
        do_req();

        do_req();
        check("underflow_one", FW'(underflow_cnt), FW'(exp_uf));

        // Early tlast drops the partial frame; next full frame is aligned.
        random_words();
        send_frame(10, 1'b1);
        check("early_last_syncerr", FW'(syncerr), 1);
        check("early_last_cnt", FW'(syncerr_cnt), 1);
        random_words();
        send_frame(NW, 1'b1);
        repeat (2) @(negedge aclk);
        do_req();
        check("aligned_cnt", FW'(syncerr_cnt), 1);

        // Missing tlast on the final word: frame kept, error counted.
        random_words();
        send_frame(NW, 1'b0);
        check("missing_last_cnt", FW'(syncerr_cnt), 2);
        repeat (2) @(negedge aclk);
        do_req();

        // Backpressure with both buffers full.
        random_words();
        send_frame(NW, 1'b1);
        random_words();
        send_frame(NW, 1'b1);
        repeat (3) @(negedge aclk);
        check("bp_tready_low", FW'(s_axis_tready), 0);
        do_req();
        check("bp_tready_back", FW'(s_axis_tready), 1);
        random_words();
        send_frame(NW, 1'b1);
        repeat (2) @(negedge aclk);
        do_req();
        do_req();
        check("bp_underflow", FW'(underflow_cnt), FW'(exp_uf));

        // Underflow counter saturation with back-to-back requests.
        req = 1'b1;
        for (int unsigned i = 0; i < 65535; i++) begin
            push_expected();
            @(negedge aclk);
        end
        req = 1'b0;
        @(negedge aclk);
        check("underflow_sat", FW'(underflow_cnt), 16'hFFFF);

        // Soft clear with hold full and a partial frame in assembly.
        random_words();
        send_frame(NW, 1'b1);
        repeat (2) @(negedge aclk);
        random_words();
        send_frame(7, 1'b0);
        clr = 1'b1;
        @(negedge aclk);
        clr = 1'b0;
        model_q.delete();
        exp_uf = 0;
        check("clr_underflow", FW'(underflow_cnt), 0);
        check("clr_syncerr_cnt", FW'(syncerr_cnt), 0);
        check("clr_syncerr", FW'(syncerr), 0);
        check("clr_tready", FW'(s_axis_tready), 1);
        check("clr_m_data", m_data, '0);
        do_req();
        check("clr_underflow_after", FW'(underflow_cnt), FW'(exp_uf));
        random_words();
        send_frame(NW, 1'b1);
        repeat (2) @(negedge aclk);
        do_req();
        check("clr_syncerr_after", FW'(syncerr_cnt), 0);

        repeat (3) @(negedge aclk);
        check("sb_drained", FW'(exp_q.size()), 0);
        check("valid_count", FW'(valid_cnt), FW'(req_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
